// File: rtl/pll_conf_sequencer.sv
// Encodes divide requests into shadow PLL counter words and pushes them to the
// scan-chain block with a one-cycle conf_req, holding them stable while busy.
module pll_conf_sequencer #(
    parameter int SCAN_CYCLES = 160,
    parameter int CNT_W       = 8
) (
    input  logic        scan_clk,
    input  logic        scan_rst,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [2:0]  wr_sel,
    input  logic [8:0]  wr_div,
    input  logic        commit,
    input  logic        err_clr,
    output logic        busy,
    output logic        err,
    output logic [17:0] clock_0_conf,
    output logic [17:0] clock_1_conf,
    output logic [17:0] clock_2_conf,
    output logic [17:0] clock_3_conf,
    output logic [17:0] clock_4_conf,
    output logic [17:0] M_config,
    output logic [17:0] N_config,
    output logic        conf_req
);

    localparam logic [17:0] BYPASS = 18'h2_0000;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [17:0]        r_shadow [0:6];
    logic [17:0]        r_active [0:6];
    logic               r_inflight;
    logic               r_enc_wr;
    logic [2:0]         r_enc_sel;
    logic [17:0]        r_enc_word;
    logic               r_commit_pend;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_err;

    logic               w_accept;
    logic               w_illegal;
    logic [7:0]         w_high;
    logic [17:0]        w_word;
    logic               w_go;
    logic               w_set_pend;
    logic               w_clr_pend;

    assign wr_ready  = ~scan_rst & (r_state == IDLE) & ~r_inflight & ~r_commit_pend;
    assign w_accept  = wr_valid & wr_ready;
    assign w_illegal = (wr_sel == 3'd7) | (wr_div == 9'd511);

    // high = ceil(div/2) written as floor(div/2) + lsb so it never overflows 8 bits
    assign w_high = wr_div[8:1] + {7'd0, wr_div[0]};

    always_comb begin
        w_word = BYPASS;
        if (wr_div >= 9'd2) begin
            w_word = {1'b0, wr_div[0], w_high, wr_div[8:1]};
        end
    end

    // A pending commit launches as soon as the in-flight shadow write lands
    assign w_go = r_commit_pend | (commit & ~r_inflight);

    always_comb begin
        w_next     = r_state;
        w_set_pend = 1'b0;
        w_clr_pend = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_go && !w_accept) begin
                    w_next     = REQ;
                    w_clr_pend = 1'b1;
                end else if (commit) begin
                    w_set_pend = 1'b1;
                end
            end
            REQ: begin
                w_next     = WAIT;
                w_set_pend = commit;
            end
            WAIT: begin
                w_set_pend = commit;
                if (r_cnt == '0) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge scan_clk) begin
        if (scan_rst) begin
            r_state       <= IDLE;
            r_commit_pend <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_state <= w_next;
            if (w_set_pend) begin
                r_commit_pend <= 1'b1;
            end else if (w_clr_pend) begin
                r_commit_pend <= 1'b0;
            end
            if (r_state == REQ) begin
                r_cnt <= CNT_W'(SCAN_CYCLES - 1);
            end else if (r_state == WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge scan_clk) begin
        if (scan_rst) begin
            r_inflight <= 1'b0;
            r_enc_wr   <= 1'b0;
            r_enc_sel  <= '0;
            r_enc_word <= BYPASS;
            r_err      <= 1'b0;
        end else begin
            r_inflight <= w_accept;
            r_enc_wr   <= w_accept & ~w_illegal;
            if (w_accept) begin
                r_enc_sel  <= wr_sel;
                r_enc_word <= w_word;
            end
            r_err <= (w_accept & w_illegal) | (r_err & ~err_clr);
        end
    end

    // Shadow takes the encoded word one cycle after acceptance; active copies only in REQ
    always_ff @(posedge scan_clk) begin
        if (scan_rst) begin
            for (int i = 0; i < 7; i++) begin
                r_shadow[i] <= BYPASS;
                r_active[i] <= BYPASS;
            end
        end else begin
            for (int i = 0; i < 7; i++) begin
                if (r_enc_wr && r_enc_sel == 3'(i)) begin
                    r_shadow[i] <= r_enc_word;
                end
                if (r_state == REQ) begin
                    r_active[i] <= r_shadow[i];
                end
            end
        end
    end

    assign busy         = ~scan_rst & (r_state != IDLE);
    assign conf_req     = ~scan_rst & (r_state == REQ);
    assign err          = ~scan_rst & r_err;
    assign clock_0_conf = r_active[0];
    assign clock_1_conf = r_active[1];
    assign clock_2_conf = r_active[2];
    assign clock_3_conf = r_active[3];
    assign clock_4_conf = r_active[4];
    assign M_config     = r_active[5];
    assign N_config     = r_active[6];

endmodule

// File: tb/tb_pll_conf_sequencer.sv
// Scoreboard bench for pll_conf_sequencer: the driver pushes expected word sets
// on each commit, and a negedge monitor pops and checks them on every conf_req.
module tb_pll_conf_sequencer;

    localparam int SCAN_CYCLES = 160;
    localparam int BUSY_LEN    = SCAN_CYCLES + 1;
    localparam logic [17:0] BYPASS = 18'h2_0000;

    logic        scan_clk = 1'b0;
    logic        scan_rst;
    logic        wr_valid;
    logic        wr_ready;
    logic [2:0]  wr_sel;
    logic [8:0]  wr_div;
    logic        commit;
    logic        err_clr;
    logic        busy;
    logic        err;
    logic [17:0] c0, c1, c2, c3, c4, mCfg, nCfg;
    logic        conf_req;

    pll_conf_sequencer #(.SCAN_CYCLES(SCAN_CYCLES), .CNT_W(8)) dut (
        .scan_clk     (scan_clk),
        .scan_rst     (scan_rst),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_sel       (wr_sel),
        .wr_div       (wr_div),
        .commit       (commit),
        .err_clr      (err_clr),
        .busy         (busy),
        .err          (err),
        .clock_0_conf (c0),
        .clock_1_conf (c1),
        .clock_2_conf (c2),
        .clock_3_conf (c3),
        .clock_4_conf (c4),
        .M_config     (mCfg),
        .N_config     (nCfg),
        .conf_req     (conf_req)
    );

    always #5 scan_clk = ~scan_clk;

    int cycle = 0;
    always @(posedge scan_clk) cycle++;

    typedef struct {
        logic [125:0] words;
        int           expCycle;
    } expItem_t;

    expItem_t     scoreQ[$];
    logic [17:0]  modelShadow [7];
    logic         modelErr;
    int           nChecks = 0;
    int           nFails  = 0;
    int           stableBad = 0;
    int           reqCount = 0;

    wire [125:0] dutWords = {nCfg, mCfg, c4, c3, c2, c1, c0};

    // Reference encoding straight from the divide rules, using plain integer math
    function automatic logic [17:0] encodeDiv(int div);
        if (div <= 1) return BYPASS;
        return 18'((div % 2) * 65536 + ((div + 1) / 2) * 256 + (div / 2));
    endfunction

    function automatic logic [125:0] packModel();
        logic [125:0] p;
        for (int i = 0; i < 7; i++) p[18*i +: 18] = modelShadow[i];
        return p;
    endfunction

    function automatic logic [125:0] allBypass();
        logic [125:0] p;
        for (int i = 0; i < 7; i++) p[18*i +: 18] = BYPASS;
        return p;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkWords(input string name, input logic [125:0] actual, input logic [125:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge scan_clk);
        #1;
    endtask

    // Bounded wait for an idle cycle in which a write would be accepted
    task automatic waitIdle();
        for (int i = 0; i < 2000; i++) begin
            @(posedge scan_clk);
            #1;
            if (wr_ready) return;
        end
        checkOutput("waitIdleTimeout", 32'd0, 32'd1);
    endtask

    task automatic applyStimulus(input int sel, input int div, input bit withCommit, input bit withClr);
        bit illegal;
        waitIdle();
        wr_valid = 1'b1;
        wr_sel   = 3'(sel);
        wr_div   = 9'(div);
        commit   = withCommit;
        err_clr  = withClr;
        illegal  = (sel == 7) || (div == 511);
        if (illegal) begin
            modelErr = 1'b1;
        end else begin
            modelShadow[sel] = encodeDiv(div);
            if (withClr) modelErr = 1'b0;
        end
        if (withCommit) scoreQ.push_back('{packModel(), cycle + 2});
        @(posedge scan_clk);
        #1;
        wr_valid = 1'b0;
        commit   = 1'b0;
        err_clr  = 1'b0;
        checkOutput("errAfterWrite", 32'(err), 32'(modelErr));
    endtask

    task automatic doCommit();
        waitIdle();
        commit = 1'b1;
        scoreQ.push_back('{packModel(), cycle + 1});
        @(posedge scan_clk);
        #1;
        commit = 1'b0;
    endtask

    task automatic pulseCommit();
        commit = 1'b1;
        @(posedge scan_clk);
        #1;
        commit = 1'b0;
    endtask

    task automatic clearErr();
        err_clr  = 1'b1;
        modelErr = 1'b0;
        @(posedge scan_clk);
        #1;
        err_clr = 1'b0;
        checkOutput("errCleared", 32'(err), 32'(modelErr));
    endtask

    // Monitor: pops an expected word set on every conf_req and tracks busy/stability
    logic [125:0] lastLoaded;
    expItem_t     cur;
    int           busyCnt = 0;
    bit           prevBusy = 0;
    bit           prevReq = 0;
    bit           loadPending = 0;

    initial lastLoaded = allBypass();

    always @(negedge scan_clk) begin
        if (scan_rst) begin
            busyCnt     = 0;
            prevBusy    = 0;
            prevReq     = 0;
            loadPending = 0;
            lastLoaded  = allBypass();
        end else begin
            if (loadPending) begin
                checkWords("activeWords", dutWords, cur.words);
                lastLoaded  = cur.words;
                loadPending = 0;
            end else if (dutWords !== lastLoaded) begin
                stableBad++;
            end
            if (conf_req) begin
                reqCount++;
                if (prevReq) checkOutput("confReqWidth", 32'd2, 32'd1);
                if (scoreQ.size() == 0) begin
                    checkOutput("unexpectedConfReq", 32'd1, 32'd0);
                end else begin
                    cur = scoreQ.pop_front();
                    if (cur.expCycle >= 0) checkOutput("reqLatency", 32'(cycle), 32'(cur.expCycle));
                    loadPending = 1;
                end
            end
            if (busy) begin
                busyCnt++;
            end else if (prevBusy) begin
                checkOutput("busyLength", 32'(busyCnt), 32'(BUSY_LEN));
                busyCnt = 0;
            end
            prevBusy = busy;
            prevReq  = conf_req;
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL globalTimeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int reqBefore;
        scan_rst = 1'b1;
        wr_valid = 1'b0;
        wr_sel   = '0;
        wr_div   = '0;
        commit   = 1'b0;
        err_clr  = 1'b0;
        modelErr = 1'b0;
        for (int i = 0; i < 7; i++) modelShadow[i] = BYPASS;

        waitCycles(3);
        checkOutput("resetWrReady", 32'(wr_ready), 32'd0);
        checkOutput("resetBusy", 32'(busy), 32'd0);
        checkOutput("resetConfReq", 32'(conf_req), 32'd0);
        scan_rst = 1'b0;
        #1;
        checkWords("resetWords", dutWords, allBypass());
        checkOutput("resetErr", 32'(err), 32'd0);

        $display("[TB] basic clock_0 commit");
        applyStimulus(0, 5, 0, 0);
        doCommit();
        waitIdle();
        checkOutput("clk0Word", 32'(c0), 32'h1_0302);

        $display("[TB] M/N/bypass commit");
        applyStimulus(5, 4, 0, 0);
        applyStimulus(6, 510, 0, 0);
        applyStimulus(1, 1, 0, 0);
        doCommit();
        waitIdle();
        checkOutput("mWord", 32'(mCfg), 32'h0_0202);
        checkOutput("nWord", 32'(nCfg), 32'h0_FFFF);
        checkOutput("clk1Bypass", 32'(c1), 32'h2_0000);

        $display("[TB] error handling");
        applyStimulus(7, 3, 0, 0);
        applyStimulus(2, 511, 0, 0);
        clearErr();
        applyStimulus(7, 0, 0, 1);
        doCommit();
        waitIdle();
        checkOutput("clk2Unchanged", 32'(c2), 32'h2_0000);
        clearErr();

        $display("[TB] write and commit in the same cycle");
        applyStimulus(3, 7, 1, 0);
        waitIdle();
        checkOutput("clk3Word", 32'(c3), 32'h1_0403);

        $display("[TB] merged commits during WAIT");
        applyStimulus(4, 9, 0, 0);
        doCommit();
        waitCycles(20);
        pulseCommit();
        waitCycles(30);
        pulseCommit();
        scoreQ.push_back('{packModel(), -1});
        waitIdle();
        waitCycles(3);
        waitIdle();
        checkOutput("mergedQueueDrained", 32'(scoreQ.size()), 32'd0);

        $display("[TB] reset during WAIT");
        applyStimulus(0, 100, 0, 0);
        doCommit();
        waitCycles(51);
        pulseCommit();
        waitCycles(2);
        scan_rst = 1'b1;
        @(posedge scan_clk);
        #1;
        scan_rst = 1'b0;
        for (int i = 0; i < 7; i++) modelShadow[i] = BYPASS;
        modelErr = 1'b0;
        checkWords("abortWords", dutWords, allBypass());
        checkOutput("abortBusy", 32'(busy), 32'd0);
        reqBefore = reqCount;
        waitCycles(300);
        checkOutput("noReqAfterReset", 32'(reqCount - reqBefore), 32'd0);

        $display("[TB] randomized writes and commits");
        for (int i = 0; i < 30; i++) begin
            int sel;
            int div;
            sel = ($urandom_range(0, 9) == 0) ? 7 : int'($urandom_range(0, 6));
            div = int'($urandom_range(0, 511));
            applyStimulus(sel, div, $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);
            if (i % 6 == 5) doCommit();
        end
        waitIdle();
        waitCycles(5);
        waitIdle();
        checkOutput("queueEmpty", 32'(scoreQ.size()), 32'd0);
        checkOutput("wordsStable", 32'(stableBad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
